// File: rtl/sysid_pkg.sv
// sysid_pkg: shared constants for the system-ID register bank.
//   - word offsets of the eight-entry register map
//   - CONTROL bit positions
//   - uptime counter width and CAPS field layout
package sysid_pkg;

    localparam logic [2:0] OFF_SYS_ID    = 3'd0;
    localparam logic [2:0] OFF_TIMESTAMP = 3'd1;
    localparam logic [2:0] OFF_UPTIME_LO = 3'd2;
    localparam logic [2:0] OFF_UPTIME_HI = 3'd3;
    localparam logic [2:0] OFF_SCRATCH   = 3'd4;
    localparam logic [2:0] OFF_CONTROL   = 3'd5;
    localparam logic [2:0] OFF_HEARTBEAT = 3'd6;
    localparam logic [2:0] OFF_CAPS      = 3'd7;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    localparam int UPTIME_W = 64;

    // CAPS layout: [7:0] address width, [8] heartbeat present
    localparam int CAPS_ADDRW_LSB = 0;
    localparam int CAPS_ADDRW_W   = 8;
    localparam int CAPS_HB_BIT    = 8;

endpackage

// File: rtl/sysid_heartbeat.sv
// sysid_heartbeat: prescaled tick counter.
//   A 32-bit prescaler runs 0..TICK_DIV-1; each wrap advances count.
//   Ports:
//     clock    in   system clock
//     reset_n  in   synchronous active-low reset
//     count    out  ticks since reset (wraps at 2^32)
module sysid_heartbeat #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] count
);

    localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

    logic [31:0] presc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            presc <= '0;
            count <= '0;
        end else if (presc == LAST) begin
            presc <= '0;
            count <= count + 32'd1;
        end else begin
            presc <= presc + 32'd1;
        end
    end

endmodule

// File: rtl/sysid_regbank.sv
// sysid_regbank: Avalon-MM system-ID slave with uptime, scratch, control
// and optional heartbeat.
//   Build option: define SYSID_HEARTBEAT_EN to include the heartbeat
//   counter (offset 6, CAPS[8]); otherwise offset 6 reads 0.
//   Ports:
//     clock          in   system clock
//     reset_n        in   synchronous active-low reset
//     address        in   word address (offsets >= 8 are unmapped)
//     chipselect     in   slave select
//     read / write   in   strobes, qualified by chipselect; write wins
//     writedata      in   write data
//     byteenable     in   write byte lanes
//     readdata       out  registered read data, held between reads
//     readdatavalid  out  pulses one cycle after an accepted read
import sysid_pkg::*;

module sysid_regbank #(
    parameter logic [31:0] SYS_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
    parameter int          ADDR_W    = 3,
    parameter int          TICK_DIV  = 50_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    // An illegal configuration decodes no registers at all.
    localparam logic PARAMS_OK = (ADDR_W >= 3) && (TICK_DIV >= 2);

    logic [31:0] heartbeat;

`ifdef SYSID_HEARTBEAT_EN
    localparam logic HB_EN = 1'b1;

    sysid_heartbeat #(.TICK_DIV(TICK_DIV)) u_heartbeat (
        .clock   (clock),
        .reset_n (reset_n),
        .count   (heartbeat)
    );
`else
    localparam logic HB_EN = 1'b0;

    assign heartbeat = '0;
`endif

    localparam logic [31:0] CAPS_WORD =
        ((32'(ADDR_W) & 32'h0000_00FF) << CAPS_ADDRW_LSB) |
        (32'(HB_EN) << CAPS_HB_BIT);

    logic [2:0]          off;
    logic                in_map;
    logic                rd_acc;
    logic                wr_hit;
    logic                clear_req;
    logic [UPTIME_W-1:0] uptime;
    logic [31:0]         hi_shadow;
    logic [31:0]         scratch;
    logic                freeze;
    logic [31:0]         rdata_nxt;

    assign off = address[2:0];

    generate
        if (ADDR_W > 3) begin : g_wide
            assign in_map = PARAMS_OK & ~|address[ADDR_W-1:3];
        end else begin : g_narrow
            assign in_map = PARAMS_OK;
        end
    endgenerate

    // A simultaneous read and write performs only the write.
    assign rd_acc    = chipselect & read & ~write;
    assign wr_hit    = chipselect & write & in_map;
    assign clear_req = wr_hit && (off == OFF_CONTROL) && byteenable[0]
                       && writedata[CTRL_CLEAR_BIT];

    always_comb begin
        rdata_nxt = '0;
        if (in_map) begin
            case (off)
                OFF_SYS_ID:    rdata_nxt = SYS_ID;
                OFF_TIMESTAMP: rdata_nxt = TIMESTAMP;
                OFF_UPTIME_LO: rdata_nxt = uptime[31:0];
                OFF_UPTIME_HI: rdata_nxt = hi_shadow;
                OFF_SCRATCH:   rdata_nxt = scratch;
                OFF_CONTROL:   rdata_nxt[CTRL_FREEZE_BIT] = freeze;
                OFF_HEARTBEAT: rdata_nxt = heartbeat;
                default:       rdata_nxt = CAPS_WORD;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            uptime        <= '0;
            hi_shadow     <= '0;
            scratch       <= '0;
            freeze        <= 1'b0;
        end else begin
            readdatavalid <= rd_acc;
            if (rd_acc)
                readdata <= rdata_nxt;

            // Reading the low word latches the matching high word, so a
            // LO-then-HI pair is a consistent 64-bit snapshot.
            if (rd_acc && in_map && (off == OFF_UPTIME_LO))
                hi_shadow <= uptime[63:32];

            if (clear_req)
                uptime <= '0;
            else if (!freeze)
                uptime <= uptime + UPTIME_W'(1);

            if (wr_hit && (off == OFF_SCRATCH)) begin
                for (int i = 0; i < 4; i++)
                    if (byteenable[i])
                        scratch[8*i +: 8] <= writedata[8*i +: 8];
            end

            if (wr_hit && (off == OFF_CONTROL) && byteenable[0])
                freeze <= writedata[CTRL_FREEZE_BIT];
        end
    end

endmodule
